mmio_irq_expstate_bridge: RTL and testbench

//  Clocked successor to the combinational MMIO/TIE passthrough in the XTSC cosim bench.

---
 rtl/mmio_irq_expstate_bridge_if.sv | 33 +++
 rtl/mmio_irq_expstate_bridge.sv | 82 ++++++++
 tb/tb_mmio_irq_expstate_bridge.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_irq_expstate_bridge_if.sv
// mmio_irq_expstate_bridge_if
//   Groups the interrupt-conditioning and EXPSTATE signals between the MMIO model side
//   and the bridge.
//   master : drives raw lines, mode/mask/clear controls and TIE_EXPSTATE; reads the results.
//   slave  : the bridge; reads the controls and drives BInterrupt, irq_pending,
//            dropped_cnt, EXPSTATE and exp_changed.
interface mmio_irq_expstate_bridge_if #(
   parameter int unsigned NUM_IRQ   = 4,
   parameter int unsigned EXP_WIDTH = 32,
   parameter int unsigned CNT_W     = 8
);
   logic [NUM_IRQ-1:0]   mmio_BInterrupt;
   logic [NUM_IRQ-1:0]   irq_edge_mode;
   logic [NUM_IRQ-1:0]   irq_mask;
   logic [NUM_IRQ-1:0]   irq_clr;
   logic                 cnt_clr;
   logic [EXP_WIDTH-1:0] TIE_EXPSTATE;
   logic [NUM_IRQ-1:0]   BInterrupt;
   logic [NUM_IRQ-1:0]   irq_pending;
   logic [CNT_W-1:0]     dropped_cnt;
   logic [EXP_WIDTH-1:0] EXPSTATE;
   logic                 exp_changed;

   modport master (
      output mmio_BInterrupt, irq_edge_mode, irq_mask, irq_clr, cnt_clr, TIE_EXPSTATE,
      input  BInterrupt, irq_pending, dropped_cnt, EXPSTATE, exp_changed
   );

   modport slave (
      input  mmio_BInterrupt, irq_edge_mode, irq_mask, irq_clr, cnt_clr, TIE_EXPSTATE,
      output BInterrupt, irq_pending, dropped_cnt, EXPSTATE, exp_changed
   );
endinterface

// File: rtl/mmio_irq_expstate_bridge.sv
// mmio_irq_expstate_bridge
//   Conditions NUM_IRQ MMIO interrupt lines for the core (level/edge mode per channel,
//   output masking, pending latches with clear, saturating dropped-edge counter) and
//   registers the TIE EXPSTATE export with a change-pulse.
// Ports
//   CLK    : core clock, all state updates on the rising edge
//   BReset : synchronous active-high reset, overrides every other input
//   bus_io : slave side of mmio_irq_expstate_bridge_if (controls in, conditioned outputs out)
module mmio_irq_expstate_bridge #(
   parameter int unsigned NUM_IRQ   = 4,
   parameter int unsigned EXP_WIDTH = 32,
   parameter int unsigned CNT_W     = 8
) (
   input logic                          CLK,
   input logic                          BReset,
   mmio_irq_expstate_bridge_if.slave    bus_io
);

   localparam int unsigned PopW = $clog2(NUM_IRQ + 1);
   // One spare bit so the sum can exceed the counter maximum before saturation.
   localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [NUM_IRQ-1:0]   sync_q, prev_q, pend_q, bint_q;
   logic [NUM_IRQ-1:0]   pend_d, bint_d, rise, pend_next, drop;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PopW-1:0]      drop_num;
   logic [SumW-1:0]      cnt_sum;
   logic [EXP_WIDTH-1:0] exp_q;
   logic                 chg_q, chg_d;

   always_comb begin
      rise      = sync_q & ~prev_q;
      // A new rise beats a simultaneous clear.
      pend_next = rise | (pend_q & ~bus_io.irq_clr);
      pend_d    = pend_next & bus_io.irq_edge_mode;
      bint_d    = ((bus_io.irq_edge_mode & pend_next) | (~bus_io.irq_edge_mode & sync_q))
                  & ~bus_io.irq_mask;
      // An edge is lost when it lands on a latch that is still set and not being cleared.
      drop      = rise & pend_q & ~bus_io.irq_clr & bus_io.irq_edge_mode;
      drop_num  = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         drop_num = drop_num + PopW'(drop[i]);
      end
      cnt_sum = SumW'(cnt_q) + SumW'(drop_num);
      if (bus_io.cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_sum > SumW'(CntMax)) begin
         cnt_d = CntMax;
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
      chg_d = (bus_io.TIE_EXPSTATE != exp_q);
   end

   always_ff @(posedge CLK) begin
      if (BReset) begin
         sync_q <= '0;
         prev_q <= '0;
         pend_q <= '0;
         bint_q <= '0;
         cnt_q  <= '0;
         exp_q  <= '0;
         chg_q  <= 1'b0;
      end else begin
         sync_q <= bus_io.mmio_BInterrupt;
         prev_q <= sync_q;
         pend_q <= pend_d;
         bint_q <= bint_d;
         cnt_q  <= cnt_d;
         exp_q  <= bus_io.TIE_EXPSTATE;
         chg_q  <= chg_d;
      end
   end

   assign bus_io.BInterrupt  = bint_q;
   assign bus_io.irq_pending = pend_q;
   assign bus_io.dropped_cnt = cnt_q;
   assign bus_io.EXPSTATE    = exp_q;
   assign bus_io.exp_changed = chg_q;

endmodule

// File: tb/tb_mmio_irq_expstate_bridge.sv
// tb_mmio_irq_expstate_bridge
//   Directed bench: a cycle-by-cycle vector table for a NUM_IRQ=4/CNT_W=8 instance,
//   followed by hand sequences for mid-run reset and counter saturation on a CNT_W=2
//   instance.
module tb_mmio_irq_expstate_bridge;

   logic CLK;
   logic BReset;
   int   total;
   int   bad;

   mmio_irq_expstate_bridge_if #(.NUM_IRQ(4), .EXP_WIDTH(32), .CNT_W(8)) bus_a ();
   mmio_irq_expstate_bridge_if #(.NUM_IRQ(4), .EXP_WIDTH(32), .CNT_W(2)) bus_b ();

   mmio_irq_expstate_bridge #(.NUM_IRQ(4), .EXP_WIDTH(32), .CNT_W(8)) dut_a (
      .CLK    (CLK),
      .BReset (BReset),
      .bus_io (bus_a)
   );

   mmio_irq_expstate_bridge #(.NUM_IRQ(4), .EXP_WIDTH(32), .CNT_W(2)) dut_b (
      .CLK    (CLK),
      .BReset (BReset),
      .bus_io (bus_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  mmio;
      logic [3:0]  em;
      logic [3:0]  mask;
      logic [3:0]  clr;
      logic        cc;
      logic [31:0] tie;
      logic [3:0]  bint;
      logic [3:0]  pend;
      logic [7:0]  cnt;
      logic [31:0] exp;
      logic        chg;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] mmio, input logic [3:0] em, input logic [3:0] mask,
                      input logic [3:0] clr, input logic cc, input logic [31:0] tie,
                      input logic [3:0] bint, input logic [3:0] pend, input logic [7:0] cnt,
                      input logic [31:0] exp, input logic chg);
      vec_t v;
      v.mmio = mmio; v.em = em; v.mask = mask; v.clr = clr; v.cc = cc; v.tie = tie;
      v.bint = bint; v.pend = pend; v.cnt = cnt; v.exp = exp; v.chg = chg;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] bint, input logic [3:0] pend,
                        input logic [7:0] cnt, input logic [31:0] exp, input logic chg);
      chk({tag, " BInterrupt"},  32'(bus_a.BInterrupt),  32'(bint));
      chk({tag, " irq_pending"}, 32'(bus_a.irq_pending), 32'(pend));
      chk({tag, " dropped_cnt"}, 32'(bus_a.dropped_cnt), 32'(cnt));
      chk({tag, " EXPSTATE"},    bus_a.EXPSTATE,         exp);
      chk({tag, " exp_changed"}, 32'(bus_a.exp_changed), 32'(chg));
   endtask

   initial begin
      int exp_cnt;
      total = 0;
      bad   = 0;
      BReset = 1'b1;
      bus_a.mmio_BInterrupt = '0; bus_a.irq_edge_mode = '0; bus_a.irq_mask = '0;
      bus_a.irq_clr = '0; bus_a.cnt_clr = 1'b0; bus_a.TIE_EXPSTATE = '0;
      bus_b.mmio_BInterrupt = '0; bus_b.irq_edge_mode = '0; bus_b.irq_mask = '0;
      bus_b.irq_clr = '0; bus_b.cnt_clr = 1'b0; bus_b.TIE_EXPSTATE = '0;

      // Level ch0 latency, edge ch1 pulse/hold/clear, clear racing a rise.
      //   mmio  em     mask   clr    cc  tie            bint   pend   cnt  exp            chg
      add(4'h1, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0); // 0
      add(4'h1, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h1, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h1, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h2, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h2, 4'h2, 0, 32'h0,        0); // 5
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h2, 4'h2, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h2, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h2, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h2, 4'h2, 0, 32'h0,        0);
      add(4'h2, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h2, 4'h2, 0, 32'h0,        0); // 10
      add(4'h0, 4'hE, 4'h0, 4'h2, 0, 32'h0,        4'h2, 4'h2, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h2, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      // Edge ch2: three rises without clear, then cnt_clr racing a drop.
      add(4'h4, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 0, 32'h0,        0);
      add(4'h4, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 0, 32'h0,        0); // 15
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 1, 32'h0,        0);
      add(4'h4, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 1, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 2, 32'h0,        0);
      add(4'h4, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h4, 4'h4, 2, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 1, 32'h0,        4'h4, 4'h4, 0, 32'h0,        0); // 20
      add(4'h0, 4'hE, 4'h0, 4'h4, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      // Masked ch3 edge, then unmask.
      add(4'h8, 4'hE, 4'h8, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h8, 4'h0, 0, 32'h0,        4'h0, 4'h8, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h8, 4'h0, 0, 32'h0,        4'h0, 4'h8, 0, 32'h0,        0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h0,        4'h8, 4'h8, 0, 32'h0,        0); // 25
      add(4'h0, 4'hE, 4'h0, 4'h8, 0, 32'h0,        4'h0, 4'h0, 0, 32'h0,        0);
      // EXPSTATE register and change pulse.
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'hDEADBEEF, 4'h0, 4'h0, 0, 32'hDEADBEEF, 1);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'hDEADBEEF, 4'h0, 4'h0, 0, 32'hDEADBEEF, 0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'hDEADBEEF, 4'h0, 4'h0, 0, 32'hDEADBEEF, 0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 1); // 30
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);
      // Mode switch edge->level drops the latch; level->edge with line high: no pending.
      add(4'h2, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h2, 4'h2, 0, 32'h12345678, 0);
      add(4'h0, 4'hC, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);
      add(4'h2, 4'hC, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0); // 35
      add(4'h2, 4'hC, 4'h0, 4'h0, 0, 32'h12345678, 4'h2, 4'h0, 0, 32'h12345678, 0);
      add(4'h2, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);
      add(4'h0, 4'hE, 4'h0, 4'h0, 0, 32'h12345678, 4'h0, 4'h0, 0, 32'h12345678, 0);

      tick();
      tick();
      chk_a("reset", 4'h0, 4'h0, 8'd0, 32'h0, 1'b0);
      chk("reset b dropped_cnt", 32'(bus_b.dropped_cnt), 32'd0);
      BReset = 1'b0;

      foreach (vq[i]) begin
         bus_a.mmio_BInterrupt = vq[i].mmio;
         bus_a.irq_edge_mode   = vq[i].em;
         bus_a.irq_mask        = vq[i].mask;
         bus_a.irq_clr         = vq[i].clr;
         bus_a.cnt_clr         = vq[i].cc;
         bus_a.TIE_EXPSTATE    = vq[i].tie;
         tick();
         chk_a($sformatf("vec%0d", i), vq[i].bint, vq[i].pend, vq[i].cnt, vq[i].exp,
               vq[i].chg);
      end

      // Build pending=0xF with dropped_cnt=5, then reset mid-run with lines held high.
      bus_a.irq_edge_mode = 4'hF;
      bus_a.irq_clr = 4'h0;
      bus_a.cnt_clr = 1'b0;
      bus_a.mmio_BInterrupt = 4'hF; tick();
      bus_a.mmio_BInterrupt = 4'h0; tick();
      bus_a.mmio_BInterrupt = 4'hF; tick();
      bus_a.mmio_BInterrupt = 4'h0; tick();
      chk("drops4 dropped_cnt", 32'(bus_a.dropped_cnt), 32'd4);
      bus_a.mmio_BInterrupt = 4'h1; tick();
      bus_a.mmio_BInterrupt = 4'h0; tick();
      chk_a("prereset", 4'hF, 4'hF, 8'd5, 32'h12345678, 1'b0);
      bus_a.mmio_BInterrupt = 4'hF;
      bus_a.TIE_EXPSTATE = 32'hDEADBEEF;
      BReset = 1'b1;
      tick();
      chk_a("midreset", 4'h0, 4'h0, 8'd0, 32'h0, 1'b0);
      tick();
      chk_a("midreset2", 4'h0, 4'h0, 8'd0, 32'h0, 1'b0);
      BReset = 1'b0;
      tick();
      chk_a("release", 4'h0, 4'h0, 8'd0, 32'hDEADBEEF, 1'b1);
      bus_a.mmio_BInterrupt = 4'h0;

      // CNT_W=2 instance: first pulse sets the latch, every later one is a drop.
      bus_b.irq_edge_mode = 4'h1;
      for (int k = 0; k < 7; k++) begin
         bus_b.mmio_BInterrupt = 4'h1; tick();
         bus_b.mmio_BInterrupt = 4'h0; tick();
         exp_cnt = (k > 3) ? 3 : k;
         chk($sformatf("sat pulse%0d dropped_cnt", k), 32'(bus_b.dropped_cnt), 32'(exp_cnt));
      end
      chk("sat irq_pending", 32'(bus_b.irq_pending), 32'h1);
      bus_b.mmio_BInterrupt = 4'h1; tick();
      bus_b.mmio_BInterrupt = 4'h0;
      bus_b.cnt_clr = 1'b1;
      tick();
      chk("cnt_clr vs drop", 32'(bus_b.dropped_cnt), 32'd0);
      bus_b.cnt_clr = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
